// File: rtl/adc_capture_nch.sv
// N-channel ADC capture: format conversion, offset subtract with saturation,
// optional 2^k block averaging and sticky per-channel over-range flags.
module adc_capture_nch #(
    parameter int unsigned N_CH         = 2,
    parameter int unsigned IN_W         = 14,
    parameter int unsigned OUT_W        = 16,
    parameter int unsigned AVG_MAX_LOG2 = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH*IN_W-1:0]    adc_d,
    input  logic [N_CH-1:0]         adc_dv,
    input  logic                    fmt_offset_bin,
    input  logic [N_CH*OUT_W-1:0]   offset,
    input  logic [2:0]              avg_log2,
    input  logic [N_CH-1:0]         ch_en,
    input  logic                    clr_ovr,
    output logic [N_CH*OUT_W-1:0]   dout,
    output logic [N_CH-1:0]         dout_valid,
    output logic [N_CH-1:0]         ovr
);

    localparam int unsigned AW = OUT_W + AVG_MAX_LOG2;
    localparam int unsigned CW = AVG_MAX_LOG2 + 1;
    localparam logic [OUT_W+1:0] DMAX = {3'b000, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W+1:0] DMIN = {3'b111, {(OUT_W-1){1'b0}}};
    localparam logic [IN_W-1:0] CODE_MIN = {1'b1, {(IN_W-1){1'b0}}};
    localparam logic [IN_W-1:0] CODE_MAX = {1'b0, {(IN_W-1){1'b1}}};
    localparam logic [2:0] K_MAX = 3'(AVG_MAX_LOG2);

    logic [2:0] k_in, k_q, k_eff;
    logic       k_chg;

    assign k_in  = (avg_log2 > K_MAX) ? K_MAX : avg_log2;
    assign k_chg = (k_in != k_q);
    // A sample landing in S3 on the change edge opens the new block under the new k.
    assign k_eff = k_chg ? k_in : k_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q <= '0;
        end else begin
            k_q <= k_in;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [IN_W-1:0]         code;
        logic                    accept, raw_ev;
        logic [OUT_W:0]          s1_d, s1_q;
        logic                    s1_vld_q, s1_ovr_q;
        logic [OUT_W-1:0]        off;
        logic signed [OUT_W+1:0] diff;
        logic                    sat_hi, sat_lo;
        logic [OUT_W-1:0]        s2_d, s2_q;
        logic                    s2_vld_q, s2_sat_q;
        logic [AW-1:0]           acc_q, acc_base, sum;
        logic signed [AW-1:0]    avg;
        logic [CW-1:0]           cnt_q, cnt_base, cnt_nxt;
        logic                    done;
        logic [OUT_W-1:0]        dout_q;
        logic                    dv_q, ovr_q, ovr_d;

        always_comb begin
            code           = adc_d[c*IN_W +: IN_W];
            code[IN_W-1]   = code[IN_W-1] ^ fmt_offset_bin;
            accept         = adc_dv[c] & ch_en[c];
            raw_ev         = (code == CODE_MIN) || (code == CODE_MAX);
            s1_d           = {{(OUT_W+1-IN_W){code[IN_W-1]}}, code};

            off            = offset[c*OUT_W +: OUT_W];
            diff           = $signed({s1_q[OUT_W], s1_q}) - $signed({{2{off[OUT_W-1]}}, off});
            sat_hi         = diff > $signed(DMAX);
            sat_lo         = diff < $signed(DMIN);
            if (sat_hi) begin
                s2_d = DMAX[OUT_W-1:0];
            end else if (sat_lo) begin
                s2_d = DMIN[OUT_W-1:0];
            end else begin
                s2_d = diff[OUT_W-1:0];
            end

            acc_base       = k_chg ? '0 : acc_q;
            cnt_base       = k_chg ? '0 : cnt_q;
            sum            = acc_base + AW'($signed(s2_q));
            cnt_nxt        = cnt_base + CW'(1);
            done           = s2_vld_q && (cnt_nxt == (CW'(1) << k_eff));
            avg            = $signed(sum) >>> k_eff;

            // Set wins over clear.
            ovr_d          = (ovr_q & ~clr_ovr) | (s1_vld_q & s1_ovr_q) | s2_sat_q;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_q     <= '0;
                s1_vld_q <= 1'b0;
                s1_ovr_q <= 1'b0;
                s2_q     <= '0;
                s2_vld_q <= 1'b0;
                s2_sat_q <= 1'b0;
                acc_q    <= '0;
                cnt_q    <= '0;
                dout_q   <= '0;
                dv_q     <= 1'b0;
                ovr_q    <= 1'b0;
            end else begin
                ovr_q    <= ovr_d;
                s1_vld_q <= accept;
                if (accept) begin
                    s1_q     <= s1_d;
                    s1_ovr_q <= raw_ev;
                end
                s2_vld_q <= s1_vld_q & ch_en[c];
                s2_sat_q <= s1_vld_q & ch_en[c] & (sat_hi | sat_lo);
                if (s1_vld_q) begin
                    s2_q <= s2_d;
                end
                dv_q <= 1'b0;
                if (!ch_en[c]) begin
                    acc_q <= '0;
                    cnt_q <= '0;
                end else if (done) begin
                    acc_q  <= '0;
                    cnt_q  <= '0;
                    dout_q <= OUT_W'(avg);
                    dv_q   <= 1'b1;
                end else if (s2_vld_q) begin
                    acc_q <= sum;
                    cnt_q <= cnt_nxt;
                end else begin
                    acc_q <= acc_base;
                    cnt_q <= cnt_base;
                end
            end
        end

        assign dout[c*OUT_W +: OUT_W] = dout_q;
        assign dout_valid[c]          = dv_q;
        assign ovr[c]                 = ovr_q;
    end

endmodule

// File: tb/tb_adc_capture_nch.sv
// Bench for adc_capture_nch: directed scenarios plus randomized traffic
// checked against an integer-arithmetic reference model.
module tb_adc_capture_nch;

    localparam int N_CH = 2;
    localparam int IN_W = 14;
    localparam int OUT_W = 16;
    localparam int AMX = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N_CH*IN_W-1:0]  adc_d;
    logic [N_CH-1:0]       adc_dv;
    logic                  fmt_offset_bin;
    logic [N_CH*OUT_W-1:0] offset;
    logic [2:0]            avg_log2;
    logic [N_CH-1:0]       ch_en;
    logic                  clr_ovr;
    logic [N_CH*OUT_W-1:0] dout;
    logic [N_CH-1:0]       dout_valid;
    logic [N_CH-1:0]       ovr;

    int checks = 0;
    int failures = 0;

    adc_capture_nch #(
        .N_CH(N_CH), .IN_W(IN_W), .OUT_W(OUT_W), .AVG_MAX_LOG2(AMX)
    ) dut (
        .clk(clk), .rst(rst), .adc_d(adc_d), .adc_dv(adc_dv),
        .fmt_offset_bin(fmt_offset_bin), .offset(offset), .avg_log2(avg_log2),
        .ch_en(ch_en), .clr_ovr(clr_ovr), .dout(dout), .dout_valid(dout_valid), .ovr(ovr)
    );

    always #5 clk = ~clk;

    // Reference model: each sample's age in the pipe, plus block sum/count per channel.
    int m_p1_v[N_CH], m_p2_v[N_CH], m_sum[N_CH], m_n[N_CH], m_dout[N_CH];
    bit m_p1_vld[N_CH], m_p1_raw[N_CH], m_p2_vld[N_CH], m_p2_sat[N_CH];
    bit m_vld[N_CH], m_ovr[N_CH];
    int m_k;

    function automatic int conv_code(int c);
        logic [IN_W-1:0] r;
        r = adc_d[c*IN_W +: IN_W];
        r[IN_W-1] = r[IN_W-1] ^ fmt_offset_bin;
        return r[IN_W-1] ? int'(r) - (1 << IN_W) : int'(r);
    endfunction

    function automatic int off_of(int c);
        logic signed [OUT_W-1:0] o;
        o = offset[c*OUT_W +: OUT_W];
        return int'(o);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_p1_v[c] = 0; m_p2_v[c] = 0; m_sum[c] = 0; m_n[c] = 0; m_dout[c] = 0;
            m_p1_vld[c] = 0; m_p1_raw[c] = 0; m_p2_vld[c] = 0; m_p2_sat[c] = 0;
            m_vld[c] = 0; m_ovr[c] = 0;
        end
        m_k = 0;
    endtask

    task automatic model_edge();
        int kin, keff, d, v;
        bit chg;
        kin = (int'(avg_log2) > AMX) ? AMX : int'(avg_log2);
        chg = (kin != m_k);
        keff = chg ? kin : m_k;
        for (int c = 0; c < N_CH; c++) begin
            m_ovr[c] = (clr_ovr ? 1'b0 : m_ovr[c]) | (m_p1_vld[c] & m_p1_raw[c]) | m_p2_sat[c];
            m_vld[c] = 0;
            if (!ch_en[c]) begin
                m_sum[c] = 0; m_n[c] = 0;
            end else begin
                if (chg) begin m_sum[c] = 0; m_n[c] = 0; end
                if (m_p2_vld[c]) begin
                    m_sum[c] += m_p2_v[c];
                    m_n[c] += 1;
                    if (m_n[c] == (1 << keff)) begin
                        m_dout[c] = m_sum[c] >>> keff;
                        m_vld[c] = 1;
                        m_sum[c] = 0; m_n[c] = 0;
                    end
                end
            end
            d = m_p1_v[c] - off_of(c);
            m_p2_sat[c] = m_p1_vld[c] & ch_en[c] & ((d > 32767) || (d < -32768));
            if (m_p1_vld[c]) m_p2_v[c] = (d > 32767) ? 32767 : ((d < -32768) ? -32768 : d);
            m_p2_vld[c] = m_p1_vld[c] & ch_en[c];
            m_p1_vld[c] = adc_dv[c] & ch_en[c];
            if (m_p1_vld[c]) begin
                v = conv_code(c);
                m_p1_v[c] = v;
                m_p1_raw[c] = (v == -(1 << (IN_W-1))) || (v == (1 << (IN_W-1)) - 1);
            end
        end
        m_k = kin;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset(); else model_edge();
        #1;
    endtask

    task automatic set_code(input int c, input int v);
        adc_d[c*IN_W +: IN_W] = IN_W'(v);
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if (dout !== '0 || dout_valid !== '0 || ovr !== '0) begin
            failures++;
            $display("FAIL reset_init got dout=%h v=%b ovr=%b want 0", dout, dout_valid, ovr);
        end
        rst = 0;
        set_code(0, 8191); set_code(1, 8191); adc_dv = 2'b11;
        repeat (4) tick();
        checks++;
        if (ovr !== 2'b11) begin
            failures++;
            $display("FAIL reset_prestream_ovr got=%b want=11", ovr);
        end
        #3 rst = 1;
        model_reset();
        #1;
        checks++;
        if (dout !== '0 || dout_valid !== '0 || ovr !== '0) begin
            failures++;
            $display("FAIL reset_async got dout=%h v=%b ovr=%b want 0", dout, dout_valid, ovr);
        end
        adc_dv = 0;
        repeat (2) tick();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dout_valid !== 2'b00) begin
                failures++;
                $display("FAIL reset_idle_valid got=%b want=00", dout_valid);
            end
        end
        set_code(0, 5); adc_dv = 2'b01;
        tick();
        adc_dv = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (dout_valid !== ((i == 1) ? 2'b01 : 2'b00)) begin
                failures++;
                $display("FAIL reset_first_latency step%0d got=%b", i, dout_valid);
            end
        end
        checks++;
        if (dout[15:0] !== 16'd5) begin
            failures++;
            $display("FAIL reset_first_data got=%h want=0005", dout[15:0]);
        end
    endtask

    task automatic test_twos_k0();
        set_code(0, 'h1FFF); set_code(1, 5); adc_dv = 2'b11;
        tick();
        adc_dv = 0;
        tick();
        checks++;
        if (dout_valid !== 2'b00 || ovr !== 2'b01) begin
            failures++;
            $display("FAIL twos_t1 got v=%b ovr=%b want v=00 ovr=01", dout_valid, ovr);
        end
        tick();
        checks++;
        if (dout_valid !== 2'b11 || dout !== {16'd5, 16'h1FFF} || ovr !== 2'b01) begin
            failures++;
            $display("FAIL twos_out got v=%b dout=%h ovr=%b want v=11 dout=00051fff ovr=01",
                     dout_valid, dout, ovr);
        end
        tick();
        checks++;
        if (dout_valid !== 2'b00) begin
            failures++;
            $display("FAIL twos_pulse got=%b want=00", dout_valid);
        end
    endtask

    task automatic test_offset_bin();
        int codes[3] = '{'h2000, 'h2010, 'h0000};
        int offs[3] = '{0, 16, 0};
        int expv[3] = '{0, 0, -8192};
        bit expo[3] = '{1'b0, 1'b0, 1'b1};
        logic [OUT_W-1:0] e;
        clr_ovr = 1; tick(); clr_ovr = 0;
        fmt_offset_bin = 1;
        for (int i = 0; i < 3; i++) begin
            offset[15:0] = 16'(offs[i]);
            set_code(0, codes[i]); adc_dv = 2'b01;
            tick();
            adc_dv = 0;
            tick(); tick();
            e = 16'(expv[i]);
            checks++;
            if (dout_valid[0] !== 1'b1 || dout[15:0] !== e || ovr[0] !== expo[i]) begin
                failures++;
                $display("FAIL offbin case%0d got v=%b d=%h ovr=%b want v=1 d=%h ovr=%b",
                         i, dout_valid[0], dout[15:0], ovr[0], e, expo[i]);
            end
            tick();
        end
        fmt_offset_bin = 0; offset = '0;
        clr_ovr = 1; tick(); clr_ovr = 0;
    endtask

    task automatic test_saturation();
        offset[15:0] = 16'h7FFF;
        set_code(0, -8192); adc_dv = 2'b01;
        tick();
        adc_dv = 0;
        tick(); tick();
        checks++;
        if (dout_valid[0] !== 1'b1 || dout[15:0] !== 16'h8000 || ovr[0] !== 1'b1) begin
            failures++;
            $display("FAIL sat_min got v=%b d=%h ovr=%b want v=1 d=8000 ovr=1",
                     dout_valid[0], dout[15:0], ovr[0]);
        end
        tick();
        set_code(0, -100); adc_dv = 2'b01;
        tick();
        adc_dv = 0; clr_ovr = 1;
        tick();
        checks++;
        if (ovr[0] !== 1'b0) begin
            failures++;
            $display("FAIL sat_clr_before got=%b want=0", ovr[0]);
        end
        tick();
        checks++;
        if (ovr[0] !== 1'b1 || dout[15:0] !== 16'h8000 || dout_valid[0] !== 1'b1) begin
            failures++;
            $display("FAIL sat_set_wins got ovr=%b d=%h v=%b want ovr=1 d=8000 v=1",
                     ovr[0], dout[15:0], dout_valid[0]);
        end
        tick();
        checks++;
        if (ovr[0] !== 1'b0) begin
            failures++;
            $display("FAIL sat_clr_alone got=%b want=0", ovr[0]);
        end
        clr_ovr = 0; offset = '0;
        tick();
    endtask

    task automatic test_averaging();
        int smp[2][4] = '{'{1, 2, 3, 5}, '{-1, -1, -1, -2}};
        logic [15:0] expd[2] = '{16'd2, 16'hFFFE};
        avg_log2 = 3'd2;
        tick();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) begin
                set_code(0, smp[b][i]); adc_dv = 2'b01;
                tick();
                checks++;
                if (dout_valid[0] !== 1'b0) begin
                    failures++;
                    $display("FAIL avg_early blk%0d s%0d got=1 want=0", b, i);
                end
            end
            adc_dv = 0;
            tick();
            checks++;
            if (dout_valid[0] !== 1'b0) begin
                failures++;
                $display("FAIL avg_early blk%0d tail got=1 want=0", b);
            end
            tick();
            checks++;
            if (dout_valid[0] !== 1'b1 || dout[15:0] !== expd[b]) begin
                failures++;
                $display("FAIL avg_out blk%0d got v=%b d=%h want v=1 d=%h",
                         b, dout_valid[0], dout[15:0], expd[b]);
            end
        end
    endtask

    task automatic test_enable_kchange();
        int nv;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 2; i++) begin
                set_code(0, (s == 0) ? 100 : 20); adc_dv = 2'b01;
                tick();
            end
            adc_dv = 0;
            repeat (3) tick();
            if (s == 0) begin
                ch_en = 2'b10; tick(); ch_en = 2'b11;
            end else begin
                avg_log2 = 3'd1; tick();
            end
            nv = 0;
            for (int i = 0; i < ((s == 0) ? 4 : 2); i++) begin
                set_code(0, (s == 0) ? 8 : 4); adc_dv = 2'b01;
                tick();
                if (dout_valid[0]) nv++;
            end
            adc_dv = 0;
            repeat (4) begin
                tick();
                if (dout_valid[0]) nv++;
            end
            checks++;
            if (nv != 1 || dout[15:0] !== ((s == 0) ? 16'd8 : 16'd4)) begin
                failures++;
                $display("FAIL %s got nvalid=%0d d=%h want nvalid=1 d=%0d",
                         (s == 0) ? "en_drop" : "k_change", nv, dout[15:0], (s == 0) ? 8 : 4);
            end
        end
    endtask

    task automatic test_random();
        logic [OUT_W-1:0] e;
        for (int cyc = 0; cyc < 600; cyc++) begin
            adc_dv = 2'($urandom);
            for (int c = 0; c < N_CH; c++) begin
                case ($urandom_range(0, 9))
                    0: set_code(c, -8192);
                    1: set_code(c, 8191);
                    default: set_code(c, int'($urandom_range(0, 16383)));
                endcase
                offset[c*OUT_W +: OUT_W] = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                         : 16'(int'($urandom_range(0, 600)) - 300);
                ch_en[c] = ($urandom_range(0, 15) != 0);
            end
            clr_ovr = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 49) == 0) fmt_offset_bin = ~fmt_offset_bin;
            if ($urandom_range(0, 59) == 0) avg_log2 = 3'($urandom_range(0, 7));
            tick();
            for (int c = 0; c < N_CH; c++) begin
                e = OUT_W'(m_dout[c]);
                checks += 3;
                if (dout[c*OUT_W +: OUT_W] !== e) begin
                    failures++;
                    $display("FAIL rnd_dout ch%0d cyc%0d got=%h want=%h",
                             c, cyc, dout[c*OUT_W +: OUT_W], e);
                end
                if (dout_valid[c] !== m_vld[c]) begin
                    failures++;
                    $display("FAIL rnd_valid ch%0d cyc%0d got=%b want=%b",
                             c, cyc, dout_valid[c], m_vld[c]);
                end
                if (ovr[c] !== m_ovr[c]) begin
                    failures++;
                    $display("FAIL rnd_ovr ch%0d cyc%0d got=%b want=%b", c, cyc, ovr[c], m_ovr[c]);
                end
            end
        end
    endtask

    initial begin
        rst = 1; adc_d = '0; adc_dv = '0; fmt_offset_bin = 0; offset = '0;
        avg_log2 = 3'd0; ch_en = '1; clr_ovr = 0;
        model_reset();
        test_reset();
        test_twos_k0();
        test_offset_bin();
        test_saturation();
        test_averaging();
        test_enable_kchange();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
